// File: rtl/dcache_direct_mapped.sv
// dcache_direct_mapped
// Direct-mapped, write-back, write-allocate data cache sitting between the
// core load/store port and one connection of the memory bus. One request is
// in flight at a time: hits finish locally, misses first write back a dirty
// victim line and then fetch the requested line over the bus.
//
// Ports
//   clk, reset                     clock (posedge) / asynchronous active-low reset
//   req_valid/req_ready            core request handshake
//   req_store/addr/wdata/wstrb     request payload (latched on accept)
//   resp_valid/resp_rdata          one-cycle completion pulse and load data
//   mem_cmd_valid/store/rready     bus command handshake and read-data ready
//   mem_cmd_addr                   line-aligned bus address
//   mem_wline                      victim line for write-back
//   mem_bus_ready/mem_bus_valid    bus command accept / fill data valid
//   mem_rline                      fill line from the bus (word 0 in LSBs)
module dcache_direct_mapped #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int CHUNKS_LOG = 4,
    parameter int SETS_LOG   = 6
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_store,
    input  logic [ADDR_WIDTH-1:0]                  req_addr,
    input  logic [DATA_WIDTH-1:0]                  req_wdata,
    input  logic [DATA_WIDTH/8-1:0]                req_wstrb,
    output logic                                   resp_valid,
    output logic [DATA_WIDTH-1:0]                  resp_rdata,
    output logic                                   mem_cmd_valid,
    output logic                                   mem_cmd_store,
    output logic                                   mem_cmd_rready,
    output logic [ADDR_WIDTH-1:0]                  mem_cmd_addr,
    output logic [DATA_WIDTH*(2**CHUNKS_LOG)-1:0]  mem_wline,
    input  logic                                   mem_bus_ready,
    input  logic                                   mem_bus_valid,
    input  logic [DATA_WIDTH*(2**CHUNKS_LOG)-1:0]  mem_rline
);

    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int WB_LOG     = $clog2(WORD_BYTES);
    localparam int LINE_BITS  = DATA_WIDTH * (2**CHUNKS_LOG);
    localparam int SETS       = 2**SETS_LOG;
    localparam int OFF_W      = WB_LOG + CHUNKS_LOG;
    localparam int IDX_W      = SETS_LOG;
    localparam int TAG_W      = ADDR_WIDTH - OFF_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT,
        RESPOND
    } state_t;

    state_t state, state_next;

    // Latched request; the byte-within-word bits are never needed.
    logic                         req_store_q;
    logic [ADDR_WIDTH-1:WB_LOG]   req_addr_q;
    logic [DATA_WIDTH-1:0]        req_wdata_q;
    logic [WORD_BYTES-1:0]        req_wstrb_q;

    logic [SETS-1:0]              valid_bits;
    logic [SETS-1:0]              dirty_bits;
    logic [TAG_W-1:0]             tag_mem  [SETS];
    logic [LINE_BITS-1:0]         line_mem [SETS];

    logic [IDX_W-1:0]             idx;
    logic [TAG_W-1:0]             tag;
    logic [CHUNKS_LOG-1:0]        word_sel;
    logic [LINE_BITS-1:0]         cur_line;
    logic [DATA_WIDTH-1:0]        cur_word;
    logic [DATA_WIDTH-1:0]        merged_word;
    logic                         hit;
    logic                         accept;
    logic                         cmd_accept;
    logic                         fill_done;

    assign idx        = req_addr_q[OFF_W +: IDX_W];
    assign tag        = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign word_sel   = req_addr_q[WB_LOG +: CHUNKS_LOG];
    assign cur_line   = line_mem[idx];
    assign cur_word   = cur_line[word_sel*DATA_WIDTH +: DATA_WIDTH];
    assign hit        = valid_bits[idx] && (tag_mem[idx] == tag);

    // Gating with reset keeps req_ready low for the whole reset interval.
    assign req_ready  = reset && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign cmd_accept = mem_cmd_valid && mem_bus_ready;
    assign fill_done  = (state == FILL_WAIT) && mem_bus_valid;

    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (req_wstrb_q[b]) begin
                merged_word[b*8 +: 8] = req_wdata_q[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A completed fill returns to LOOKUP so the request is replayed as a hit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    state_next = RESPOND;
                end else if (valid_bits[idx] && dirty_bits[idx]) begin
                    state_next = WB_REQ;
                end else begin
                    state_next = FILL_REQ;
                end
            end
            WB_REQ:    if (cmd_accept) state_next = FILL_REQ;
            FILL_REQ:  if (cmd_accept) state_next = FILL_WAIT;
            FILL_WAIT: if (mem_bus_valid) state_next = LOOKUP;
            RESPOND:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_store_q <= req_store;
            req_addr_q  <= req_addr[ADDR_WIDTH-1:WB_LOG];
            req_wdata_q <= req_wdata;
            req_wstrb_q <= req_wstrb;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill_done) begin
            valid_bits[idx] <= 1'b1;
            dirty_bits[idx] <= 1'b0;
        end else if (state == LOOKUP && hit && req_store_q) begin
            dirty_bits[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid_bits guards them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            line_mem[idx] <= mem_rline;
            tag_mem[idx]  <= tag;
        end else if (state == LOOKUP && hit && req_store_q) begin
            line_mem[idx][word_sel*DATA_WIDTH +: DATA_WIDTH] <= merged_word;
        end
    end

    // The command register only loads a new command when it is empty, so an
    // accepted write-back leaves one idle cycle before the fill command rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            mem_cmd_valid  <= 1'b0;
            mem_cmd_store  <= 1'b0;
            mem_cmd_rready <= 1'b0;
            mem_cmd_addr   <= '0;
            mem_wline      <= '0;
        end else begin
            resp_valid     <= (state_next == RESPOND);
            resp_rdata     <= (state == LOOKUP && hit && !req_store_q) ? cur_word : '0;
            mem_cmd_rready <= (state_next == FILL_WAIT);
            if (mem_cmd_valid) begin
                if (mem_bus_ready) begin
                    mem_cmd_valid <= 1'b0;
                end
            end else if (state_next == WB_REQ) begin
                mem_cmd_valid <= 1'b1;
                mem_cmd_store <= 1'b1;
                mem_cmd_addr  <= {tag_mem[idx], idx, {OFF_W{1'b0}}};
                mem_wline     <= cur_line;
            end else if (state_next == FILL_REQ) begin
                mem_cmd_valid <= 1'b1;
                mem_cmd_store <= 1'b0;
                mem_cmd_addr  <= {tag, idx, {OFF_W{1'b0}}};
            end
        end
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
module tb_dcache_direct_mapped;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int LB = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [7:0]    req_wstrb;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          mem_cmd_valid;
    logic          mem_cmd_store;
    logic          mem_cmd_rready;
    logic [AW-1:0] mem_cmd_addr;
    logic [LB-1:0] mem_wline;
    logic          mem_bus_ready;
    logic          mem_bus_valid;
    logic [LB-1:0] mem_rline;

    int assertions = 0;
    int failures   = 0;

    dcache_direct_mapped dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_cmd_valid  (mem_cmd_valid),
        .mem_cmd_store  (mem_cmd_store),
        .mem_cmd_rready (mem_cmd_rready),
        .mem_cmd_addr   (mem_cmd_addr),
        .mem_wline      (mem_wline),
        .mem_bus_ready  (mem_bus_ready),
        .mem_bus_valid  (mem_bus_valid),
        .mem_rline      (mem_rline)
    );

    always #5 clk = ~clk;

    function automatic logic [LB-1:0] make_line(input logic [63:0] base);
        logic [LB-1:0] l;
        for (int w = 0; w < 16; w++) l[w*64 +: 64] = base + 64'(w);
        return l;
    endfunction

    function automatic logic [LB-1:0] set_word(input logic [LB-1:0] line, input int w,
                                               input logic [63:0] val);
        logic [LB-1:0] l;
        l = line;
        l[w*64 +: 64] = val;
        return l;
    endfunction

    // Reports the first differing 64-bit word so lines stay readable.
    task automatic checkOutput(input string tag, input logic [LB-1:0] observed,
                               input logic [LB-1:0] expected);
        int wi;
        assertions++;
        if (observed !== expected) begin
            failures++;
            wi = 0;
            for (int i = 0; i < 16; i++) begin
                if (observed[i*64 +: 64] !== expected[i*64 +: 64]) begin
                    wi = i;
                    break;
                end
            end
            $display("[TB] FAIL %s: word %0d observed %h expected %h", tag, wi,
                     observed[wi*64 +: 64], expected[wi*64 +: 64]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request while the cache is idle; it is accepted on the next edge.
    task automatic applyStimulus(input logic st, input logic [63:0] a,
                                 input logic [63:0] wd, input logic [7:0] ws);
        checkOutput("req_ready_idle", LB'(req_ready), LB'(1));
        req_valid = 1'b1;
        req_store = st;
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = ws;
        tick();
        req_valid = 1'b0;
        req_store = 1'b0;
    endtask

    // Waits for the completion pulse, counting cycles since the call.
    task automatic finishResp(input string tag, input logic [63:0] exp_data,
                              input int exp_lat, input logic chk_nocmd);
        int   lat;
        logic saw_cmd;
        lat = 0;
        saw_cmd = 1'b0;
        while (!resp_valid && lat < 200) begin
            if (mem_cmd_valid) saw_cmd = 1'b1;
            tick();
            lat++;
        end
        if (mem_cmd_valid) saw_cmd = 1'b1;
        if (!resp_valid) begin
            checkOutput({tag, "_timeout"}, LB'(0), LB'(1));
        end else begin
            checkOutput({tag, "_data"}, LB'(resp_rdata), LB'(exp_data));
            checkOutput({tag, "_latency"}, LB'(lat), LB'(exp_lat));
            if (chk_nocmd) checkOutput({tag, "_no_cmd"}, LB'(saw_cmd), LB'(0));
            tick();
            checkOutput({tag, "_pulse"}, LB'(resp_valid), LB'(0));
            checkOutput({tag, "_idle"}, LB'(req_ready), LB'(1));
        end
    endtask

    // Acts as the bus for one command, optionally stalling it first.
    task automatic serveCmd(input string tag, input logic exp_store, input logic [63:0] exp_addr,
                            input logic chk_wline, input logic [LB-1:0] exp_wline, input int hold);
        int n;
        n = 0;
        while (!mem_cmd_valid && n < 50) begin
            tick();
            n++;
        end
        if (!mem_cmd_valid) begin
            checkOutput({tag, "_cmd_timeout"}, LB'(0), LB'(1));
            return;
        end
        checkOutput({tag, "_store"}, LB'(mem_cmd_store), LB'(exp_store));
        checkOutput({tag, "_addr"}, LB'(mem_cmd_addr), LB'(exp_addr));
        if (chk_wline) checkOutput({tag, "_wline"}, mem_wline, exp_wline);
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput({tag, "_hold_valid"}, LB'(mem_cmd_valid), LB'(1));
            checkOutput({tag, "_hold_addr"}, LB'(mem_cmd_addr), LB'(exp_addr));
            checkOutput({tag, "_hold_ready"}, LB'(req_ready), LB'(0));
            checkOutput({tag, "_hold_resp"}, LB'(resp_valid), LB'(0));
        end
        mem_bus_ready = 1'b1;
        tick();
        mem_bus_ready = 1'b0;
        checkOutput({tag, "_drop"}, LB'(mem_cmd_valid), LB'(0));
    endtask

    task automatic serveFill(input string tag, input logic [LB-1:0] line);
        int n;
        n = 0;
        while (!mem_cmd_rready && n < 50) begin
            tick();
            n++;
        end
        if (!mem_cmd_rready) begin
            checkOutput({tag, "_rready_timeout"}, LB'(0), LB'(1));
            return;
        end
        mem_rline     = line;
        mem_bus_valid = 1'b1;
        tick();
        mem_bus_valid = 1'b0;
        mem_rline     = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, LB'(req_ready), LB'(0));
        checkOutput({tag, "_resp_valid"}, LB'(resp_valid), LB'(0));
        checkOutput({tag, "_resp_rdata"}, LB'(resp_rdata), LB'(0));
        checkOutput({tag, "_cmd_valid"}, LB'(mem_cmd_valid), LB'(0));
        checkOutput({tag, "_cmd_store"}, LB'(mem_cmd_store), LB'(0));
        checkOutput({tag, "_cmd_rready"}, LB'(mem_cmd_rready), LB'(0));
        checkOutput({tag, "_cmd_addr"}, LB'(mem_cmd_addr), LB'(0));
        checkOutput({tag, "_wline"}, mem_wline, LB'(0));
    endtask

    initial begin
        logic [LB-1:0] line1, line2, line3, merged1, merged2;
        line1   = make_line(64'h0000_0000_0000_00AA);
        line2   = make_line(64'h3333_4444_5555_0000);
        line3   = make_line(64'h7777_0000_0000_0010);
        merged1 = set_word(line1, 0, 64'h0000_0000_5566_7788);
        merged2 = set_word(line2, 0, 64'hDEAD_BEEF_0123_4567);

        reset         = 1'b0;
        req_valid     = 1'b0;
        req_store     = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_wstrb     = '0;
        mem_bus_ready = 1'b0;
        mem_bus_valid = 1'b0;
        mem_rline     = '0;

        tick();
        tick();
        checkResetOutputs("reset");
        reset = 1'b1;
        tick();

        // Cold miss on a clean set: straight to the fill, no write-back.
        $display("[TB] cold load miss 0x1000");
        applyStimulus(1'b0, 64'h1000, '0, '0);
        serveCmd("t1_fill", 1'b0, 64'h1000, 1'b0, '0, 0);
        serveFill("t1", line1);
        finishResp("t1_resp", 64'hAA, 1, 1'b0);

        $display("[TB] load hit 0x1008");
        applyStimulus(1'b0, 64'h1008, '0, '0);
        finishResp("t2_hit", 64'hAB, 1, 1'b1);

        $display("[TB] partial store then reload 0x1000");
        applyStimulus(1'b1, 64'h1000, 64'h1122_3344_5566_7788, 8'h0F);
        finishResp("t3_store", 64'h0, 1, 1'b1);
        applyStimulus(1'b0, 64'h1000, '0, '0);
        finishResp("t3_load", 64'h0000_0000_5566_7788, 1, 1'b1);

        // Conflict miss evicts the dirty line; fill command is stalled by the bus.
        $display("[TB] conflict miss 0x3000 with write-back and stalled fill");
        applyStimulus(1'b0, 64'h3000, '0, '0);
        serveCmd("t4_wb", 1'b1, 64'h1000, 1'b1, merged1, 0);
        serveCmd("t5_fill", 1'b0, 64'h3000, 1'b1, merged1, 10);
        serveFill("t4", line2);
        finishResp("t4_resp", 64'h3333_4444_5555_0000, 1, 1'b0);

        // Dirty the resident line, then reset while a fill is outstanding.
        $display("[TB] reset during fill wait");
        applyStimulus(1'b1, 64'h3000, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        finishResp("t6_store", 64'h0, 1, 1'b1);
        applyStimulus(1'b0, 64'h1008, '0, '0);
        serveCmd("t6_wb", 1'b1, 64'h3000, 1'b1, merged2, 0);
        serveCmd("t6_fill", 1'b0, 64'h1000, 1'b0, '0, 0);
        checkOutput("t6_in_fill_wait", LB'(mem_cmd_rready), LB'(1));
        reset = 1'b0;
        #1;
        checkResetOutputs("t6_reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // All lines invalid after reset, so no write-back of the dirty 0x3000 line.
        applyStimulus(1'b0, 64'h1008, '0, '0);
        serveCmd("t6_refill", 1'b0, 64'h1000, 1'b0, '0, 0);
        serveFill("t6", line3);
        finishResp("t6_resp", 64'h7777_0000_0000_0011, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
